// File: rtl/read_return_dispatch_if.sv
// Read-return stream, issue notification, writeback handshake and status
// bundle for the read-return dispatcher.
interface read_return_dispatch_if #(
  parameter int DEPTH   = 8,
  parameter int THREADS = 4,
  parameter int ID_W    = 2,
  parameter int RID_W   = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10
);
  logic                       ret_valid;
  logic [DATA_W-1:0]          ret_data;
  logic [ID_W-1:0]            ret_request_id;
  logic [RID_W-1:0]           ret_receive_id;
  logic [ADDR_W-1:0]          ret_address;
  logic                       issue_valid;
  logic [ID_W-1:0]            issue_thread;
  logic                       halt;
  logic                       wb_valid;
  logic                       wb_ready;
  logic [ID_W-1:0]            wb_thread;
  logic [RID_W-1:0]           wb_reg;
  logic [DATA_W-1:0]          wb_data;
  logic [ADDR_W-1:0]          wb_address;
  logic [THREADS-1:0]         pending;
  logic [$clog2(DEPTH):0]     fifo_count;
  logic                       err;

  modport slave (
    input  ret_valid, ret_data, ret_request_id, ret_receive_id, ret_address,
    input  issue_valid, issue_thread, wb_ready,
    output halt, wb_valid, wb_thread, wb_reg, wb_data, wb_address,
    output pending, fifo_count, err
  );

  modport master (
    output ret_valid, ret_data, ret_request_id, ret_receive_id, ret_address,
    output issue_valid, issue_thread, wb_ready,
    input  halt, wb_valid, wb_thread, wb_reg, wb_data, wb_address,
    input  pending, fifo_count, err
  );
endinterface

// File: rtl/read_return_dispatch.sv
// Buffers storage read returns in a show-ahead FIFO, hands them to the
// register writeback port, tracks outstanding reads per thread, drives halt.
module read_return_dispatch #(
  parameter int DEPTH       = 8,
  parameter int THREADS     = 4,
  parameter int ID_W        = 2,
  parameter int RID_W       = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int CNT_W       = 4,
  parameter int HALT_MARGIN = 2
) (
  input logic                clk,
  input logic                rst,
  read_return_dispatch_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]   HALT_TH  = CW'(DEPTH - HALT_MARGIN);
  localparam logic [ID_W:0]   THR_LIM  = (ID_W + 1)'(THREADS);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [RID_W-1:0]  rid;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t             mem_p0 [DEPTH];
  entry_t             wr_entry;
  entry_t             head_p0;
  logic [AW-1:0]      wr_ptr_p0;
  logic [AW-1:0]      rd_ptr_p0;
  logic [CW-1:0]      count_p0;
  logic [CW-1:0]      count_next;
  logic               halt_p0;
  logic               err_p0;
  logic               vld_p0;
  logic               enq;
  logic               deq;
  logic               drop;
  logic               bad_id;
  logic               head_bad;
  logic [CNT_W-1:0]   cnt_p0   [THREADS];
  logic [CNT_W-1:0]   cnt_next [THREADS];
  logic [THREADS-1:0] inc_t;
  logic [THREADS-1:0] dec_t;
  logic [THREADS-1:0] cnt_err;
  logic [THREADS-1:0] pend;

  // Saturating up/down step; MSB of the result flags an over/underflow attempt.
  function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] c,
                                               input logic inc,
                                               input logic dec);
    if (inc && !dec)
      return (&c) ? {1'b1, c} : {1'b0, c + 1'b1};
    else if (dec && !inc)
      return (c == '0) ? {1'b1, c} : {1'b0, c - 1'b1};
    else
      return {1'b0, c};
  endfunction

  assign wr_entry = '{id:   bus.ret_request_id,
                      rid:  bus.ret_receive_id,
                      data: bus.ret_data,
                      addr: bus.ret_address};
  assign head_p0  = mem_p0[rd_ptr_p0];
  assign vld_p0   = (count_p0 != '0);
  assign deq      = vld_p0 && bus.wb_ready;
  assign enq      = bus.ret_valid && ((count_p0 != FULL_CNT) || deq);
  assign drop     = bus.ret_valid && !enq;
  assign bad_id   = bus.ret_valid && ({1'b0, bus.ret_request_id} >= THR_LIM);
  assign head_bad = ({1'b0, head_p0.id} >= THR_LIM);

  always_comb begin
    count_next = count_p0;
    case ({enq, deq})
      2'b10:   count_next = count_p0 + 1'b1;
      2'b01:   count_next = count_p0 - 1'b1;
      default: count_next = count_p0;
    endcase
  end

  always_comb begin
    for (int t = 0; t < THREADS; t++) begin
      inc_t[t] = bus.issue_valid && (bus.issue_thread == ID_W'(t));
      dec_t[t] = deq && !head_bad && (head_p0.id == ID_W'(t));
      {cnt_err[t], cnt_next[t]} = cnt_step(cnt_p0[t], inc_t[t], dec_t[t]);
      pend[t] = (cnt_p0[t] != '0);
    end
  end

  // Storage stage: entry payload is not reset, only pointers qualify it.
  always_ff @(posedge clk) begin
    if (enq)
      mem_p0[wr_ptr_p0] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      count_p0  <= '0;
      halt_p0   <= 1'b0;
      err_p0    <= 1'b0;
      for (int t = 0; t < THREADS; t++)
        cnt_p0[t] <= '0;
    end else begin
      if (enq)
        wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
      if (deq)
        rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
      count_p0 <= count_next;
      halt_p0  <= (count_next >= HALT_TH);
      err_p0   <= err_p0 | drop | bad_id | (|cnt_err);
      for (int t = 0; t < THREADS; t++)
        cnt_p0[t] <= cnt_next[t];
    end
  end

  // Writeback stage: payload reads as zero whenever the FIFO is empty.
  assign bus.wb_valid   = vld_p0;
  assign bus.wb_thread  = vld_p0 ? head_p0.id   : '0;
  assign bus.wb_reg     = vld_p0 ? head_p0.rid  : '0;
  assign bus.wb_data    = vld_p0 ? head_p0.data : '0;
  assign bus.wb_address = vld_p0 ? head_p0.addr : '0;
  assign bus.halt       = halt_p0;
  assign bus.err        = err_p0;
  assign bus.fifo_count = count_p0;
  assign bus.pending    = pend;

endmodule
